// File: rtl/scan_display_ctrl.sv
// Time-multiplexed NUM_DIGITS x 7-segment controller with a frame-synchronous shadow buffer,
// hex decode and leading-zero blanking. Optional brightness PWM: define BRIGHTNESS_PWM_EN.
module scan_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lzb_en,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]              duty,
`endif
  output logic [NUM_DIGITS-1:0]   select,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0]         SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   select_q, select_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end, wrap, in_window, zero_above;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   blank_vec;

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]  duty_q, duty_d;
  logic [39:0] win_lhs, win_rhs;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    slot_end   = (slot_cnt_q == SLOT_LAST);
    wrap       = slot_end && (idx_q == IDX_LAST);
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CW'(1);
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // Shadow only changes at the frame boundary; a load on that very cycle bypasses pending.
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (wrap) begin
      if (load) begin
        shadow_d    = data_in;
        shadow_dp_d = dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        shadow_d    = pend_q;
        shadow_dp_d = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end else if (load) begin
      pend_d      = data_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end

    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above && (shadow_q[4*i +: 4] == 4'h0);
      blank_vec[i] = zero_above && (i != 0);
    end
    cur_nib = shadow_q[4*int'(idx_q) +: 4];

`ifdef BRIGHTNESS_PWM_EN
    duty_d    = (slot_cnt_q == '0) ? duty : duty_q;
    win_lhs   = 40'(slot_cnt_q) << 4;
    win_rhs   = 40'({1'b0, duty_d} + 5'd1) * 40'(SCAN_DIV);
    in_window = (win_lhs < win_rhs);
`else
    in_window = 1'b1;
`endif

    select_d     = in_window ? ((NUM_DIGITS'(1) << idx_q) ^ SEL_OFF) : SEL_OFF;
    seg_d        = (lzb_en && blank_vec[idx_q]) ? 7'b0 : hex7(cur_nib);
    dp_d         = shadow_dp_q[idx_q];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      select_q     <= SEL_OFF;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      select_q     <= select_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_q <= 4'hF;
    else     duty_q <= duty_d;
  end
`endif

  assign select     = select_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl (4 digits, 16-cycle slots) with an active-low select twin.
module tb_scan_display_ctrl;

  localparam int N  = 4;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  duty = 4'hF;
  logic [3:0]  select, select_al;
  logic [6:0]  seg_out, seg_al;
  logic        dp_out, dp_al, frame_done, fd_al;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] cap_seg[N];
  logic       cap_dp[N];
  logic [3:0] cap_sel[N];
  logic [6:0] exp_seg[N];
  logic       exp_dp[N];

  scan_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .SEL_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load), .lzb_en(lzb_en),
`ifdef BRIGHTNESS_PWM_EN
    .duty(duty),
`endif
    .select(select), .seg_out(seg_out), .dp_out(dp_out), .frame_done(frame_done)
  );

  scan_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .SEL_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load), .lzb_en(lzb_en),
`ifdef BRIGHTNESS_PWM_EN
    .duty(duty),
`endif
    .select(select_al), .seg_out(seg_al), .dp_out(dp_al), .frame_done(fd_al)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl[16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
            7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tbl[n];
  endfunction

  task automatic wait_frame_done();
    int k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_timeout: got %b want 1", frame_done);
    end
  endtask

  // Called on the negedge where frame_done is seen; samples each digit's slot.
  task automatic capture_digits();
    for (int d = 0; d < N; d++) begin
      repeat ((d == 0) ? 1 : SD) @(negedge clk);
      cap_seg[d] = seg_out;
      cap_dp[d]  = dp_out;
      cap_sel[d] = select;
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic compare_frame(input string name);
    for (int d = 0; d < N; d++) begin
      n_checks++;
      if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== exp_dp[d] || cap_sel[d] !== 4'(1 << d)) begin
        n_fail++;
        $display("FAIL %s digit%0d: seg=%b dp=%b sel=%b want seg=%b dp=%b sel=%b",
                 name, d, cap_seg[d], cap_dp[d], cap_sel[d], exp_seg[d], exp_dp[d], 4'(1 << d));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (select !== 4'b0000 || seg_out !== 7'b0 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sel=%b seg=%b dp=%b fd=%b want all 0", select, seg_out, dp_out, frame_done);
    end
    n_checks++;
    if (select_al !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_sel_active_low: got %b want 1111", select_al);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel;
    int fd_count = 0;
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      exp_sel = 4'(1 << (((n - 1) / SD) % N));
      n_checks++;
      if (select !== exp_sel || select_al !== ~exp_sel) begin
        n_fail++;
        $display("FAIL scan_select n=%0d: got %b/%b want %b/%b", n, select, select_al, exp_sel, ~exp_sel);
      end
      n_checks++;
      if (frame_done !== ((n % 64) == 0)) begin
        n_fail++;
        $display("FAIL scan_frame_done n=%0d: got %b want %b", n, frame_done, (n % 64) == 0);
      end
      if (frame_done === 1'b1) fd_count++;
      if (n == 1) begin
        n_checks++;
        if (seg_out !== 7'b1111110 || seg_al !== 7'b1111110 || dp_out !== 1'b0 || dp_al !== 1'b0) begin
          n_fail++;
          $display("FAIL scan_first_seg: got %b/%b dp=%b want 1111110 dp=0", seg_out, seg_al, dp_out);
        end
      end
    end
    n_checks++;
    if (fd_count != 2 || fd_al !== frame_done) begin
      n_fail++;
      $display("FAIL scan_fd_count: got %0d want 2", fd_count);
    end
  endtask

  task automatic test_load();
    wait_frame_done();
    repeat (20) @(negedge clk);
    load_word(16'h12AF, 4'b0100);
    @(negedge clk);
    n_checks++;
    if (seg_out !== 7'b1111110) begin
      n_fail++;
      $display("FAIL load_mid_frame_hold: got %b want 1111110", seg_out);
    end
    wait_frame_done();
    capture_digits();
    exp_seg = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};
    exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b0};
    compare_frame("load_12AF");
  endtask

  task automatic test_back_to_back();
    load_word(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    load_word(16'h2222, 4'b0000);
    wait_frame_done();
    capture_digits();
    for (int d = 0; d < N; d++) begin
      exp_seg[d] = 7'b1101101;
      exp_dp[d]  = 1'b0;
    end
    compare_frame("two_loads");
  endtask

  task automatic test_wrap_load();
    wait_frame_done();
    load_word(16'h4444, 4'b0000);
    repeat (62) @(negedge clk);
    data_in = 16'h3333;
    dp_in   = 4'b0001;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load_boundary: fd=%b want 1", frame_done);
    end
    capture_digits();
    for (int d = 0; d < N; d++) begin
      exp_seg[d] = 7'b1111001;
      exp_dp[d]  = (d == 0);
    end
    compare_frame("wrap_load");
  endtask

  task automatic test_lzb();
    lzb_en = 1'b1;
    load_word(16'h0050, 4'b0000);
    wait_frame_done();
    capture_digits();
    exp_seg = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
    exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0};
    compare_frame("lzb_0050");
    load_word(16'h0000, 4'b1000);
    wait_frame_done();
    capture_digits();
    exp_seg = '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000};
    exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b1};
    compare_frame("lzb_0000");
    lzb_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    load_word(16'h5555, 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (select !== 4'b0000 || seg_out !== 7'b0 || dp_out !== 1'b0 || frame_done !== 1'b0 || select_al !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: sel=%b seg=%b dp=%b fd=%b sel_al=%b want 0/0/0/0/1111",
               select, seg_out, dp_out, frame_done, select_al);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k = 1;
    n_checks++;
    if (select !== 4'b0001 || seg_out !== 7'b1111110) begin
      n_fail++;
      $display("FAIL reset_mid_restart: sel=%b seg=%b want 0001 1111110", select, seg_out);
    end
    while (frame_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 64) begin
      n_fail++;
      $display("FAIL reset_mid_first_fd: after %0d cycles want 64", k);
    end
    capture_digits();
    for (int d = 0; d < N; d++) begin
      exp_seg[d] = 7'b1111110;
      exp_dp[d]  = 1'b0;
    end
    compare_frame("reset_discards_pending");
  endtask

`ifdef BRIGHTNESS_PWM_EN
  task automatic test_pwm();
    int on_cnt = 0;
    duty = 4'd3;
    wait_frame_done();
    for (int n = 1; n <= SD; n++) begin
      @(negedge clk);
      if (select === 4'b0001) on_cnt++;
    end
    n_checks++;
    if (on_cnt != 4) begin
      n_fail++;
      $display("FAIL pwm_duty3: active %0d cycles want 4", on_cnt);
    end
    duty = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_wrap_load();
    test_lzb();
    test_reset_mid();
`ifdef BRIGHTNESS_PWM_EN
    test_pwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
